// File: rtl/alu_issue_stage.sv
// Issue stage for an external 16-bit add/subtract unit.
// Commands are registered onto the unit and its result is flagged, then queued in a 2-entry FIFO.
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic [8:0]  in_op,
    output logic [15:0] arith_a,
    output logic [15:0] arith_b,
    output logic [8:0]  arith_sel,
    input  logic [15:0] arith_sum,
    input  logic        arith_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic [4:0]  out_flags
);

    localparam logic [8:0] OP_ADD = 9'h02B;
    localparam logic [8:0] OP_SUB = 9'h02D;

    typedef enum logic [1:0] {IDLE, EXEC, WRITE} state_t;

    typedef struct packed {
        logic [15:0] sum;
        logic [4:0]  flags;   // {err, ovf, carry, neg, zero}
    } entry_t;

    state_t     state, state_next;
    logic       run;
    entry_t     staging, result;
    entry_t     mem [2];
    logic       head, tail;
    logic [1:0] count;
    logic       accept, push, pop, full;
    logic       is_add, is_sub, ovf_add, ovf_sub, borrow;

    // in_ready stays low until the first edge after reset release.
    assign in_ready  = run && (state == IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (count != 2'd0);
    assign full      = (count == 2'd2);
    assign pop       = out_valid && out_ready;
    assign push      = (state == WRITE) && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every clocked register uses <= so all flops update from pre-edge values.
        if (!rst_n) begin
            state <= IDLE;
            run   <= 1'b0;
        end else begin
            state <= state_next;
            run   <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = WRITE;
            WRITE:   if (push) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign is_add  = (arith_sel == OP_ADD);
    assign is_sub  = (arith_sel == OP_SUB);
    assign borrow  = (arith_a < arith_b);
    assign ovf_add = (arith_a[15] == arith_b[15]) && (arith_sum[15] != arith_a[15]);
    assign ovf_sub = (arith_a[15] != arith_b[15]) && (arith_sum[15] != arith_a[15]);

    always_comb begin
        result = '0;
        if (is_add) begin
            result.sum   = arith_sum;
            result.flags = {1'b0, ovf_add, arith_cout, arith_sum[15], arith_sum == 16'h0000};
        end else if (is_sub) begin
            result.sum   = arith_sum;
            result.flags = {1'b0, ovf_sub, borrow, arith_sum[15], arith_sum == 16'h0000};
        end else begin
            result.flags = 5'b10001;
        end
    end

    // Operands hold through EXEC and any WRITE stall; only an accept reloads them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arith_a   <= '0;
            arith_b   <= '0;
            arith_sel <= '0;
            staging   <= '0;
        end else begin
            if (accept) begin
                arith_a   <= in_a;
                arith_b   <= in_b;
                arith_sel <= in_op;
            end
            if (state == EXEC) staging <= result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) tail <= ~tail;
            if (pop)  head <= ~head;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // NOTE: FIFO storage is not reset; count gates visibility, so stale contents never escape.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= staging;
    end

    assign out_sum   = mem[head].sum;
    assign out_flags = mem[head].flags;

endmodule
